rs_pipe_addsub: RTL and testbench
=================================

# rs_pipe_addsub

Parametrised, pipelined add/subtract/accumulate unit for Genesis3 fabric. Words wider than one carry chain are split into `SEG_WIDTH` segments. Each segment resolves in its own pipeline stage, and the carry is registered between stages, so no combinational chain exceeds `SEG_WIDTH` bits. A skewed per-segment accumulator lets back-to-back accumulate operations issue every cycle without hazards. The block sits between datapath producers and consumers using valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width; must be ≥1.
- `SEG_WIDTH`, 32, bits per carry-chain segment; must satisfy 1 ≤ `SEG_WIDTH` ≤ `MAX_CARRY_CHAIN`. Elaboration error otherwise.
- `NSEG` (derived), ceil(`WIDTH`/`SEG_WIDTH`). The top segment holds the remaining bits and may be narrower.

Ports:
- `C` in 1: clock. One clock; reset is synchronous and active-low.
- `R` in 1: synchronous active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted on an edge where `in_valid & in_ready`.
- `op` in 2: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- `a` in `WIDTH`: operand A; ignored for ACC/LOAD.
- `b` in `WIDTH`: operand B.
- `ci` in 1: carry-in for ADD and ACC; ignored for SUB/LOAD.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer ready.
- `y` out `WIDTH`: result.
- `co` out 1: carry out of MSB. For SUB, 1 = no borrow.
- `ovf` out 1: two's-complement overflow, i.e. carry into MSB xor carry out of MSB.

## Operation
- ADD: y = a + b + ci.
- SUB: y = a + ~b + 1. `ci` is ignored.
- ACC: y = acc + b + ci, and acc ← y.
- LOAD: y = b, acc ← b, co = 0, ovf = 0.
- Stage k (0..NSEG-1) computes segment k. Its carry-in is `ci`/1 for k = 0; otherwise it is the registered carry from stage k-1.
- Stage k registers segments 0..k of the result, the unconsumed operand segments k+1..NSEG-1, the carry, `op`, and a valid bit.
- Accumulator storage is per segment: `acc_seg[k]`. Stage k reads `acc_seg[k]` combinationally and writes it on the edge that advances an ACC/LOAD out of stage k.
  - Consecutive ACCs therefore see each predecessor's segment k before using it.
  - Issuing ACC every cycle is hazard-free.
- `co` and `ovf` are formed in the final stage from the top segment's MSB carries.
- Global stall: `adv = ~out_valid | out_ready`.
  - All stage registers and `acc_seg` update only when `adv` = 1.
  - `in_ready = adv`.
  - Bubbles (valid = 0) propagate and never write `acc_seg`.
- Results leave strictly in accept order. No reordering and no drops.
- Arithmetic is modulo 2^`WIDTH`. Carry out of bit `WIDTH`-1 appears only on `co`.

## Timing
- Reset (`R` = 0 at an edge) has priority over every other event. It clears:
  - all stage valid bits;
  - `acc_seg` to 0;
  - `out_valid`, `y`, `co` and `ovf` to 0.
  
  `in_ready` is 1 in the cycle after reset. An operation in flight during reset is discarded and never appears at the output.
- Latency: an op accepted at edge t appears with `out_valid` = 1 after edge t+NSEG-1. That is NSEG cycles including the accept cycle; NSEG = 1 gives a registered single-cycle result.
- Throughput: one op per cycle while `out_ready` = 1.
- `out_valid` & ~`out_ready`: `y`/`co`/`ovf` hold stable and `in_ready` = 0 in the same cycle (combinational from `out_ready`). There is no other combinational path from inputs to outputs.
- `out_ready` may rise at any time. Data is consumed on the edge where `out_valid & out_ready`, and the next stage value moves in on that same edge.
- ACC accepted while an older ACC is still in flight sees the older result, segment by segment.

## Structure
- Shared package `rs_arith_pkg`:
  - `op` enum (`OP_ADD`, `OP_SUB`, `OP_ACC`, `OP_LOAD`);
  - `MAX_CARRY_CHAIN` constant;
  - `nseg(width, seg)` function.
- Sub-module `rs_addsub_seg`: combinational `SEG_WIDTH` adder (a, b, cin → sum, cout, msb_cin). It maps onto one `adder_carry` chain. The top module instantiates NSEG of them, each with its own width.

## Test plan
Default parameters (NSEG = 2) unless stated.
- ADD a=0xFFFF_FFFF, b=1, ci=0 → y=0x1_0000_0000, co=0, ovf=0, `out_valid` 2 cycles after accept.
- SUB 0 − 1 → y=0xFFFF_FFFF_FFFF_FFFF, co=0, ovf=0. Then SUB 0x8000_0000_0000_0000 − 1 → y=0x7FFF_FFFF_FFFF_FFFF, co=1, ovf=1.
- Back-to-back LOAD b=5, ACC b=3, ACC b=0xFFFF_FFFF (ci=0, no gaps) → y=5, 8, 0x1_0000_0007 on consecutive cycles.
- Two ops in flight, then `out_ready` = 0 for 3 cycles → `in_ready` = 0, y stable, no duplication or loss. Resume → both results delivered in order.
- Pipeline full of ACCs, `R` = 0 for one edge → `out_valid` = 0 and y = 0 next cycle, and no stale result emerges. Then ACC b=7 → y=7.
- WIDTH=40, SEG_WIDTH=16 (NSEG=3): ADD 0xFF_FFFF_FFFF + 1 → y=0, co=1, ovf=0, latency 3. SEG_WIDTH > `MAX_CARRY_CHAIN` → elaboration error.

Source files
------------

// File: rtl/rs_arith_pkg.sv
// Shared arithmetic definitions for the rs_* datapath blocks: opcodes, the
// longest permitted carry chain and the segment-count helper.
package rs_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    localparam int MAX_CARRY_CHAIN = 64;

    // Number of carry-chain segments needed to cover a word of the given width.
    function automatic int nseg(input int width, input int seg);
        if (seg < 1) begin
            return 1;
        end
        return (width + seg - 1) / seg;
    endfunction

endpackage

// File: rtl/rs_addsub_seg.sv
// One carry-chain segment: W-bit add with carry-in, exposing the carry out of
// the top bit and the carry into it (needed for signed overflow).
module rs_addsub_seg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);

    logic [W:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum     = total[W-1:0];
    assign cout    = total[W];
    // Carry into the MSB recovered from the MSB sum bit.
    assign msb_cin = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/rs_pipe_addsub.sv
// Pipelined add/sub/accumulate: one carry-chain segment resolved per stage,
// registered carries between stages, per-segment skewed accumulator.
module rs_pipe_addsub
    import rs_arith_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 32
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf
);

    localparam int NSEG = nseg(WIDTH, SEG_WIDTH);

    if (WIDTH < 1 || SEG_WIDTH < 1 || SEG_WIDTH > MAX_CARRY_CHAIN) begin : g_param_check
        $error("rs_pipe_addsub: WIDTH must be >= 1 and SEG_WIDTH in 1..MAX_CARRY_CHAIN");
    end

    op_t op_in;
    logic adv;

    logic             valid_reg [NSEG];
    op_t              op_reg    [NSEG];
    logic             carry_reg [NSEG];
    logic [WIDTH-1:0] a_reg     [NSEG];
    logic [WIDTH-1:0] b_reg     [NSEG];
    logic [WIDTH-1:0] res_reg   [NSEG];
    logic             co_reg, ovf_reg;
    logic             co_next, ovf_next;
    logic [WIDTH-1:0] acc_reg, acc_next;

    // What each stage computes on: the port inputs for stage 0, the previous
    // stage's registers otherwise.
    logic             src_valid [NSEG];
    op_t              src_op    [NSEG];
    logic             src_carry [NSEG];
    logic [WIDTH-1:0] src_a     [NSEG];
    logic [WIDTH-1:0] src_b     [NSEG];
    logic [WIDTH-1:0] src_res   [NSEG];

    logic [WIDTH-1:0] res_next  [NSEG];
    logic [WIDTH-1:0] seg_mask  [NSEG];
    logic [WIDTH-1:0] sum_ext   [NSEG];
    logic             seg_cout  [NSEG];
    logic             seg_msbc  [NSEG];
    logic             acc_wr    [NSEG];

    assign op_in     = op_t'(op);
    assign adv       = ~valid_reg[NSEG-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_reg[NSEG-1];
    assign y         = res_reg[NSEG-1];
    assign co        = co_reg;
    assign ovf       = ovf_reg;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int LO = gi * SEG_WIDTH;
        localparam int SW = (WIDTH - LO < SEG_WIDTH) ? (WIDTH - LO) : SEG_WIDTH;

        logic [SW-1:0] opa, opb, sum;
        logic          cin;

        if (gi == 0) begin : g_head
            assign src_valid[gi] = in_valid;
            assign src_op[gi]    = op_in;
            assign src_a[gi]     = a;
            assign src_b[gi]     = b;
            assign src_res[gi]   = '0;
            assign src_carry[gi] = (op_in == OP_SUB) |
                                   (((op_in == OP_ADD) || (op_in == OP_ACC)) & ci);
        end else begin : g_body
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_op[gi]    = op_reg[gi-1];
            assign src_a[gi]     = a_reg[gi-1];
            assign src_b[gi]     = b_reg[gi-1];
            assign src_res[gi]   = res_reg[gi-1];
            assign src_carry[gi] = carry_reg[gi-1];
        end

        // ACC reads this stage's accumulator slice, already updated by any
        // older ACC that left this stage on the previous edge.
        always_comb begin
            case (src_op[gi])
                OP_ACC:  opa = acc_reg[LO +: SW];
                OP_LOAD: opa = '0;
                default: opa = src_a[gi][LO +: SW];
            endcase
            opb = (src_op[gi] == OP_SUB) ? ~src_b[gi][LO +: SW] : src_b[gi][LO +: SW];
            cin = (src_op[gi] == OP_LOAD) ? 1'b0 : src_carry[gi];
        end

        rs_addsub_seg #(.W(SW)) u_seg (
            .a       (opa),
            .b       (opb),
            .cin     (cin),
            .sum     (sum),
            .cout    (seg_cout[gi]),
            .msb_cin (seg_msbc[gi])
        );

        assign seg_mask[gi] = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;
        assign sum_ext[gi]  = WIDTH'(sum) << LO;
        assign res_next[gi] = (src_res[gi] & ~seg_mask[gi]) | sum_ext[gi];
        assign acc_wr[gi]   = src_valid[gi] &
                              ((src_op[gi] == OP_ACC) || (src_op[gi] == OP_LOAD));
    end

    always_comb begin
        acc_next = acc_reg;
        for (int k = 0; k < NSEG; k++) begin
            if (acc_wr[k]) begin
                acc_next = (acc_next & ~seg_mask[k]) | sum_ext[k];
            end
        end
    end

    always_comb begin
        co_next  = 1'b0;
        ovf_next = 1'b0;
        if (src_op[NSEG-1] != OP_LOAD) begin
            co_next  = seg_cout[NSEG-1];
            ovf_next = seg_cout[NSEG-1] ^ seg_msbc[NSEG-1];
        end
    end

    always_ff @(posedge C) begin
        if (!R) begin
            for (int k = 0; k < NSEG; k++) begin
                valid_reg[k] <= 1'b0;
                op_reg[k]    <= OP_ADD;
                carry_reg[k] <= 1'b0;
                a_reg[k]     <= '0;
                b_reg[k]     <= '0;
                res_reg[k]   <= '0;
            end
            co_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            acc_reg <= '0;
        end else if (adv) begin
            for (int k = 0; k < NSEG; k++) begin
                valid_reg[k] <= src_valid[k];
                op_reg[k]    <= src_op[k];
                carry_reg[k] <= seg_cout[k];
                a_reg[k]     <= src_a[k];
                b_reg[k]     <= src_b[k];
                res_reg[k]   <= res_next[k];
            end
            co_reg  <= co_next;
            ovf_reg <= ovf_next;
            acc_reg <= acc_next;
        end
    end

endmodule

// File: tb/tb_rs_pipe_addsub.sv
// Directed bench for rs_pipe_addsub: default 64/32 build plus a 40/16 build
// with a narrow top segment.
module tb_rs_pipe_addsub;

    logic        C;
    logic        R;

    logic        in_valid, in_ready, ci, out_valid, out_ready, co, ovf;
    logic [1:0]  op;
    logic [63:0] a, b, y;

    logic        in_valid2, in_ready2, ci2, out_valid2, out_ready2, co2, ovf2;
    logic [1:0]  op2;
    logic [39:0] a2, b2, y2;

    int check_cnt = 0;
    int pass_cnt  = 0;

    rs_pipe_addsub #(.WIDTH(64), .SEG_WIDTH(32)) u_dut (
        .C(C), .R(R),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .co(co), .ovf(ovf)
    );

    rs_pipe_addsub #(.WIDTH(40), .SEG_WIDTH(16)) u_dut_w40 (
        .C(C), .R(R),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .a(a2), .b(b2), .ci(ci2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .y(y2), .co(co2), .ovf(ovf2)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            pass_cnt++;
            $display("check %s = 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv,
                         input logic c);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        ci       = c;
    endtask

    task automatic step();
        @(negedge C);
    endtask

    initial begin
        R = 1'b0;
        in_valid = 1'b0; op = 2'b00; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0; ci2 = 1'b0; out_ready2 = 1'b1;

        // Reset state
        step(); step();
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_y", y, 64'd0);
        check_val("rst_co", {63'd0, co}, 64'd0);
        check_val("rst_ovf", {63'd0, ovf}, 64'd0);
        R = 1'b1;
        step();
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD carrying across the segment boundary, latency 2
        drive(2'b00, 64'hFFFF_FFFF, 64'd1, 1'b0);
        step();
        in_valid = 1'b0;
        check_val("add_lat_early", {63'd0, out_valid}, 64'd0);
        step();
        check_val("add_valid", {63'd0, out_valid}, 64'd1);
        check_val("add_y", y, 64'h1_0000_0000);
        check_val("add_co", {63'd0, co}, 64'd0);
        check_val("add_ovf", {63'd0, ovf}, 64'd0);

        // SUB borrow and signed overflow
        drive(2'b01, 64'd0, 64'd1, 1'b1);
        step();
        drive(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        step();
        in_valid = 1'b0;
        check_val("sub0_y", y, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("sub0_co", {63'd0, co}, 64'd0);
        check_val("sub0_ovf", {63'd0, ovf}, 64'd0);
        step();
        check_val("sub1_y", y, 64'h7FFF_FFFF_FFFF_FFFF);
        check_val("sub1_co", {63'd0, co}, 64'd1);
        check_val("sub1_ovf", {63'd0, ovf}, 64'd1);

        // LOAD then back-to-back ACCs
        step();
        drive(2'b11, 64'hDEAD, 64'd5, 1'b1);
        step();
        drive(2'b10, 64'hBEEF, 64'd3, 1'b0);
        check_val("acc_lat_early", {63'd0, out_valid}, 64'd0);
        step();
        drive(2'b10, 64'd0, 64'hFFFF_FFFF, 1'b0);
        check_val("load_valid", {63'd0, out_valid}, 64'd1);
        check_val("load_y", y, 64'd5);
        check_val("load_co", {63'd0, co}, 64'd0);
        step();
        in_valid = 1'b0;
        check_val("acc1_valid", {63'd0, out_valid}, 64'd1);
        check_val("acc1_y", y, 64'd8);
        step();
        check_val("acc2_valid", {63'd0, out_valid}, 64'd1);
        check_val("acc2_y", y, 64'h1_0000_0007);
        check_val("acc2_co", {63'd0, co}, 64'd0);
        step();
        check_val("acc_drain", {63'd0, out_valid}, 64'd0);

        // Back-pressure with two ops in flight
        drive(2'b00, 64'd1, 64'd2, 1'b0);
        step();
        drive(2'b00, 64'd10, 64'd20, 1'b0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_val("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check_val("stall_y0", y, 64'd3);
        for (int i = 1; i <= 2; i++) begin
            step();
            check_val($sformatf("stall_valid%0d", i), {63'd0, out_valid}, 64'd1);
            check_val($sformatf("stall_y%0d", i), y, 64'd3);
            check_val($sformatf("stall_rdy%0d", i), {63'd0, in_ready}, 64'd0);
        end
        step();
        out_ready = 1'b1;
        #1;
        check_val("resume_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("resume_y_first", y, 64'd3);
        step();
        check_val("resume_valid2", {63'd0, out_valid}, 64'd1);
        check_val("resume_y_second", y, 64'd30);
        step();
        check_val("resume_drain", {63'd0, out_valid}, 64'd0);

        // Reset with ACCs in flight
        drive(2'b10, 64'd0, 64'd1, 1'b0);
        step();
        drive(2'b10, 64'd0, 64'd2, 1'b0);
        step();
        in_valid = 1'b0;
        R = 1'b0;
        step();
        R = 1'b1;
        check_val("mrst_valid", {63'd0, out_valid}, 64'd0);
        check_val("mrst_y", y, 64'd0);
        check_val("mrst_co", {63'd0, co}, 64'd0);
        check_val("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        check_val("mrst_no_stale", {63'd0, out_valid}, 64'd0);
        drive(2'b10, 64'd0, 64'd7, 1'b0);
        step();
        in_valid = 1'b0;
        check_val("mrst_no_stale2", {63'd0, out_valid}, 64'd0);
        step();
        check_val("post_rst_acc_valid", {63'd0, out_valid}, 64'd1);
        check_val("post_rst_acc_y", y, 64'd7);

        // 40-bit word, three segments (16/16/8)
        in_valid2 = 1'b1;
        op2 = 2'b00;
        a2  = 40'hFF_FFFF_FFFF;
        b2  = 40'd1;
        ci2 = 1'b0;
        step();
        in_valid2 = 1'b0;
        check_val("w40_lat1", {63'd0, out_valid2}, 64'd0);
        step();
        check_val("w40_lat2", {63'd0, out_valid2}, 64'd0);
        step();
        check_val("w40_valid", {63'd0, out_valid2}, 64'd1);
        check_val("w40_y", {24'd0, y2}, 64'd0);
        check_val("w40_co", {63'd0, co2}, 64'd1);
        check_val("w40_ovf", {63'd0, ovf2}, 64'd0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
